// File: rtl/bundle_pkg.sv
// Shared types and sizing helpers for the NAND-multiplexing bundle decoder.
package bundle_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } dec_state_t;

  // Width needed to hold a count in the range 0..n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Number of CHUNK-wide slices covering an n-line bundle.
  function automatic int unsigned num_chunks(input int unsigned n, input int unsigned chunk);
    if (chunk == 0) return 1;
    return (n + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/bundle_threshold_decoder_chunk_popcount.sv
// Combinational popcount of one masked CHUNK-bit slice of the bundle.
module chunk_popcount #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0]             slice,
  input  logic [CHUNK-1:0]             mask,
  output logic [$clog2(CHUNK+1)-1:0]   count
);

  localparam int unsigned PC_W = $clog2(CHUNK + 1);

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      count = count + PC_W'(slice[i] & mask[i]);
    end
  end

endmodule

// File: rtl/bundle_threshold_decoder.sv
// Serial bundle popcounter: counts CHUNK lines per cycle, then classifies the
// bundle as stimulated / unstimulated / ambiguous and keeps an ambiguity tally.
module bundle_threshold_decoder
  import bundle_pkg::*;
#(
  parameter int unsigned N         = 10,
  parameter int unsigned CHUNK     = 4,
  parameter int unsigned LO_THRESH = 1,
  parameter int unsigned HI_THRESH = 9,
  parameter int unsigned STAT_W    = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N-1:0]               z_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  output logic                       bit_o,
  output logic [$clog2(N+1)-1:0]     count_o,
  output logic                       ambiguous_o,
  output logic                       valid_o,
  output logic [STAT_W-1:0]          amb_total_o
);

  localparam int unsigned CNT_W  = cnt_width(N);
  localparam int unsigned NCHUNK = num_chunks(N, CHUNK);
  localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned PC_W   = $clog2(CHUNK + 1);

  localparam logic [CNT_W:0] N_EXT  = (CNT_W + 1)'(N);
  localparam logic [CNT_W:0] LO_EXT = (CNT_W + 1)'(LO_THRESH);
  localparam logic [CNT_W:0] HI_EXT = (CNT_W + 1)'(HI_THRESH);

  if (LO_THRESH >= HI_THRESH) begin : g_bad_thresh
    $error("bundle_threshold_decoder: LO_THRESH must be below HI_THRESH");
  end
  if (HI_THRESH > N) begin : g_bad_hi
    $error("bundle_threshold_decoder: HI_THRESH exceeds N");
  end
  if (CHUNK < 1 || CHUNK > N) begin : g_bad_chunk
    $error("bundle_threshold_decoder: CHUNK must lie in 1..N");
  end

  dec_state_t        state, next_state;
  logic [N-1:0]      shift_q;
  logic [CNT_W-1:0]  acc_q;
  logic [IDX_W-1:0]  chunk_idx;
  logic [CHUNK-1:0]  chunk_mask;
  logic [PC_W-1:0]   chunk_cnt;
  logic [CNT_W-1:0]  acc_next;
  logic              last_chunk;
  logic [CNT_W:0]    cnt_ext;
  logic [CNT_W:0]    two_cnt;
  logic              bit_next;
  logic              amb_next;

  // Lanes beyond N in the final partial slice are masked off.
  always_comb begin
    chunk_mask = '0;
    for (int unsigned l = 0; l < CHUNK; l++) begin
      chunk_mask[l] = ((32'(chunk_idx) * CHUNK + l) < N);
    end
  end

  chunk_popcount #(.CHUNK(CHUNK)) u_chunk_popcount (
    .slice (shift_q[CHUNK-1:0]),
    .mask  (chunk_mask),
    .count (chunk_cnt)
  );

  always_comb begin
    acc_next   = acc_q + CNT_W'(chunk_cnt);
    last_chunk = (chunk_idx == IDX_W'(NCHUNK - 1));
    cnt_ext    = {1'b0, acc_next};
    two_cnt    = {acc_next, 1'b0};
    bit_next   = (two_cnt > N_EXT);
    amb_next   = (cnt_ext > LO_EXT) && (cnt_ext < HI_EXT);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    ready_o    = (state == IDLE);
    case (state)
      IDLE:    if (valid_i)    next_state = COUNT;
      COUNT:   if (last_chunk) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shift_q     <= '0;
      acc_q       <= '0;
      chunk_idx   <= '0;
      bit_o       <= 1'b0;
      count_o     <= '0;
      ambiguous_o <= 1'b0;
      valid_o     <= 1'b0;
      amb_total_o <= '0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_i) begin
            shift_q   <= z_i;
            acc_q     <= '0;
            chunk_idx <= '0;
          end
        end
        COUNT: begin
          shift_q   <= shift_q >> CHUNK;
          acc_q     <= acc_next;
          chunk_idx <= chunk_idx + 1'b1;
          if (last_chunk) begin
            count_o     <= acc_next;
            bit_o       <= bit_next;
            ambiguous_o <= amb_next;
            valid_o     <= 1'b1;
            if (amb_next && (amb_total_o != '1)) amb_total_o <= amb_total_o + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bundle_threshold_decoder.sv
// Directed self-checking bench for bundle_threshold_decoder (N=10, CHUNK=4).
module tb_bundle_threshold_decoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  z_i;
  logic        valid_i;
  logic        ready_o, bit_o, ambiguous_o, valid_o;
  logic [3:0]  count_o;
  logic [15:0] amb_total_o;
  logic        s_ready_o, s_bit_o, s_ambiguous_o, s_valid_o;
  logic [3:0]  s_count_o;
  logic [1:0]  s_amb_total_o;

  int vectors     = 0;
  int miscompares = 0;
  int exp_tot     = 0;

  always #5 clk = ~clk;

  bundle_threshold_decoder #(
    .N(10), .CHUNK(4), .LO_THRESH(1), .HI_THRESH(9), .STAT_W(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .z_i(z_i), .valid_i(valid_i),
    .ready_o(ready_o), .bit_o(bit_o), .count_o(count_o),
    .ambiguous_o(ambiguous_o), .valid_o(valid_o), .amb_total_o(amb_total_o)
  );

  // Same traffic, 2-bit statistics counter to exercise saturation.
  bundle_threshold_decoder #(
    .N(10), .CHUNK(4), .LO_THRESH(1), .HI_THRESH(9), .STAT_W(2)
  ) dut_sat (
    .clk(clk), .reset_n(reset_n), .z_i(z_i), .valid_i(valid_i),
    .ready_o(s_ready_o), .bit_o(s_bit_o), .count_o(s_count_o),
    .ambiguous_o(s_ambiguous_o), .valid_o(s_valid_o), .amb_total_o(s_amb_total_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one bundle on the next edge, then check the 3-edge latency and result.
  task automatic run_bundle(input logic [9:0] z, input int cnt, input int b, input int amb);
    chk("ready_before_accept", 32'(ready_o), 1);
    z_i = z;
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("valid_latency", 32'(valid_o), (k == 3) ? 1 : 0);
    end
    if (amb != 0) exp_tot++;
    chk("count_o",     32'(count_o), 32'(cnt));
    chk("bit_o",       32'(bit_o), 32'(b));
    chk("ambiguous_o", 32'(ambiguous_o), 32'(amb));
    chk("ready_at_result", 32'(ready_o), 1);
    chk("amb_total_o", 32'(amb_total_o), 32'(exp_tot));
    chk("amb_total_sat", 32'(s_amb_total_o), (exp_tot > 3) ? 3 : 32'(exp_tot));
  endtask

  logic [9:0] stream_z [12];
  int         stream_cnt [3];

  initial begin
    reset_n = 1'b0;
    valid_i = 1'b0;
    z_i     = '0;
    step();
    step();
    chk("reset_valid", 32'(valid_o), 0);
    chk("reset_count", 32'(count_o), 0);
    chk("reset_total", 32'(amb_total_o), 0);
    reset_n = 1'b1;
    step();
    chk("reset_ready", 32'(ready_o), 1);

    // All lines stimulated; result then holds while valid_o drops.
    run_bundle(10'h3FF, 10, 1, 0);
    step();
    chk("valid_pulse_width", 32'(valid_o), 0);
    chk("count_hold", 32'(count_o), 10);

    run_bundle(10'h000, 0, 0, 0);
    run_bundle(10'h001, 1, 0, 0);
    run_bundle(10'h01F, 5, 0, 1);
    run_bundle(10'h3E0, 5, 0, 1);
    run_bundle(10'h3FE, 9, 1, 0);
    run_bundle(10'h300, 2, 0, 1);

    // valid_i held high: only every 4th pulse lands while ready_o is high.
    stream_z = '{10'h3FF, 10'h000, 10'h000, 10'h000,
                 10'h01F, 10'h3FF, 10'h3FF, 10'h3FF,
                 10'h001, 10'h3FF, 10'h3FF, 10'h3FF};
    stream_cnt = '{10, 5, 1};
    valid_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      z_i = stream_z[i];
      step();
      chk("stream_valid", 32'(valid_o), ((i % 4) == 3) ? 1 : 0);
      chk("stream_ready", 32'(ready_o), ((i % 4) == 3) ? 1 : 0);
      if ((i % 4) == 3) chk("stream_count", 32'(count_o), 32'(stream_cnt[i / 4]));
    end
    valid_i = 1'b0;
    exp_tot++;
    chk("stream_total", 32'(amb_total_o), 32'(exp_tot));
    chk("stream_total_sat", 32'(s_amb_total_o), 3);

    // Reset asserted on the second count edge of an all-ones bundle.
    z_i = 10'h3FF;
    valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    step();
    reset_n = 1'b0;
    step();
    chk("midreset_valid", 32'(valid_o), 0);
    chk("midreset_count", 32'(count_o), 0);
    chk("midreset_bit",   32'(bit_o), 0);
    chk("midreset_amb",   32'(ambiguous_o), 0);
    chk("midreset_total", 32'(amb_total_o), 0);
    reset_n = 1'b1;
    exp_tot = 0;
    step();
    chk("midreset_ready", 32'(ready_o), 1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("midreset_no_valid", 32'(valid_o), 0);
    end

    // Four ambiguous bundles: 16-bit tally reaches 4, 2-bit tally pins at 3.
    run_bundle(10'h01F, 5, 0, 1);
    run_bundle(10'h3E0, 5, 0, 1);
    run_bundle(10'h300, 2, 0, 1);
    run_bundle(10'h0F0, 4, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
